store_drain_buffer: RTL and testbench

//  Committed-store buffer and load/store request arbiter. Sits directly upstream of mem_system
//  and drives its single data-memory request channel. Queues retired stores in order, issues

---
 rtl/store_drain_buffer.sv | 223 ++++++++++++++++++++++
 tb/tb_store_drain_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_buffer.sv
// Committed-store drain buffer and single-channel load/store request arbiter for mem_system.
// Define SB_FWD_EN to forward full-strobe buffered store data to aliasing loads.
module store_drain_buffer #(
    parameter int DEPTH      = 4,
    parameter int XLEN       = 32,
    parameter int LDTAG_W    = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       st_valid_i,
    output logic                       st_ready_o,
    input  logic [XLEN-1:0]            st_addr_i,
    input  logic [XLEN-1:0]            st_wdata_i,
    input  logic [XLEN/8-1:0]          st_wstrb_i,
    input  logic                       ld_valid_i,
    output logic                       ld_ready_o,
    input  logic [XLEN-1:0]            ld_addr_i,
    input  logic [LDTAG_W-1:0]         ld_tag_i,
    output logic                       mreq_valid_o,
    input  logic                       mreq_ready_i,
    output logic                       mreq_we_o,
    output logic [XLEN-1:0]            mreq_addr_o,
    output logic [XLEN-1:0]            mreq_wdata_o,
    output logic [XLEN/8-1:0]          mreq_wstrb_o,
    output logic [LDTAG_W-1:0]         mreq_tag_o,
    output logic                       fwd_valid_o,
    output logic [LDTAG_W-1:0]         fwd_tag_o,
    output logic [XLEN-1:0]            fwd_data_o,
    output logic                       sb_empty_o,
    output logic [$clog2(DEPTH):0]     sb_count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam int BW = XLEN / 8;

    typedef enum logic {IDLE, HOLD} state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [SW-1:0]      starve_q, starve_d;

    logic [XLEN-1:0]    ent_addr_q [DEPTH];
    logic [XLEN-1:0]    ent_data_q [DEPTH];
    logic [BW-1:0]      ent_strb_q [DEPTH];

    logic               mreq_we_q, mreq_we_d;
    logic [XLEN-1:0]    mreq_addr_q, mreq_addr_d;
    logic [XLEN-1:0]    mreq_wdata_q, mreq_wdata_d;
    logic [BW-1:0]      mreq_wstrb_q, mreq_wstrb_d;
    logic [LDTAG_W-1:0] mreq_tag_q, mreq_tag_d;

    logic               enq, hs, st_pop, can_issue, head_avail;
    logic [PW-1:0]      head_idx, idx;
    logic               live, hit_buf, hit_inc, ld_alias;
    logic               fwd_ok, fwd_take, ld_cand, st_prio, pick_st, pick_ld;
    logic [XLEN-3:0]    ld_word;
`ifdef SB_FWD_EN
    logic [PW-1:0]      yng_idx;
`endif

    assign st_ready_o   = (count_q < CW'(DEPTH));
    assign enq          = st_valid_i && st_ready_o;
    assign mreq_valid_o = (state_q == HOLD);
    assign hs           = mreq_valid_o && mreq_ready_i;
    assign st_pop       = hs && mreq_we_q;
    assign can_issue    = (state_q == IDLE) || hs;
    // A store handshaking this cycle frees the slot, so the next entry is the candidate.
    assign head_idx     = st_pop ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    assign head_avail   = can_issue && (count_q > CW'(st_pop));
    assign ld_word      = ld_addr_i[XLEN-1:2];

    // Scan oldest to youngest so the last hit is the youngest matching entry.
    always_comb begin
        hit_buf = 1'b0;
        idx     = '0;
        live    = 1'b0;
`ifdef SB_FWD_EN
        yng_idx = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx  = rd_ptr_q + PW'(k);
            live = (CW'(k) < count_q) && !(st_pop && (k == 0));
            if (live && (ent_addr_q[idx][XLEN-1:2] == ld_word)) begin
                hit_buf = 1'b1;
`ifdef SB_FWD_EN
                yng_idx = idx;
`endif
            end
        end
    end

    assign hit_inc  = enq && (st_addr_i[XLEN-1:2] == ld_word);
    assign ld_alias = hit_buf || hit_inc;

`ifdef SB_FWD_EN
    assign fwd_ok = hit_buf && !hit_inc && (&ent_strb_q[yng_idx]);
`else
    assign fwd_ok = 1'b0;
`endif

    assign fwd_take   = ld_valid_i && fwd_ok;
    assign ld_cand    = can_issue && ld_valid_i && !ld_alias;
    assign st_prio    = (count_q == CW'(DEPTH)) || (starve_q >= SW'(STARVE_LIM));
    assign pick_st    = head_avail && (st_prio || !ld_cand);
    assign pick_ld    = ld_cand && !pick_st;
    assign ld_ready_o = pick_ld || fwd_take;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + CW'(enq) - CW'(st_pop);
        starve_d     = starve_q;
        mreq_we_d    = mreq_we_q;
        mreq_addr_d  = mreq_addr_q;
        mreq_wdata_d = mreq_wdata_q;
        mreq_wstrb_d = mreq_wstrb_q;
        mreq_tag_d   = mreq_tag_q;

        if (enq)    wr_ptr_d = wr_ptr_q + PW'(1);
        if (st_pop) rd_ptr_d = rd_ptr_q + PW'(1);

        if (pick_st) begin
            starve_d = '0;
        end else if (head_avail && (starve_q < SW'(STARVE_LIM))) begin
            starve_d = starve_q + SW'(1);
        end

        if (pick_st) begin
            state_d      = HOLD;
            mreq_we_d    = 1'b1;
            mreq_addr_d  = ent_addr_q[head_idx];
            mreq_wdata_d = ent_data_q[head_idx];
            mreq_wstrb_d = ent_strb_q[head_idx];
            mreq_tag_d   = '0;
        end else if (pick_ld) begin
            state_d      = HOLD;
            mreq_we_d    = 1'b0;
            mreq_addr_d  = ld_addr_i;
            mreq_wdata_d = '0;
            mreq_wstrb_d = '0;
            mreq_tag_d   = ld_tag_i;
        end else if (hs) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            mreq_we_q    <= 1'b0;
            mreq_addr_q  <= '0;
            mreq_wdata_q <= '0;
            mreq_wstrb_q <= '0;
            mreq_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            mreq_we_q    <= mreq_we_d;
            mreq_addr_q  <= mreq_addr_d;
            mreq_wdata_q <= mreq_wdata_d;
            mreq_wstrb_q <= mreq_wstrb_d;
            mreq_tag_q   <= mreq_tag_d;
        end
    end

    // Entry payload needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            ent_addr_q[wr_ptr_q] <= st_addr_i;
            ent_data_q[wr_ptr_q] <= st_wdata_i;
            ent_strb_q[wr_ptr_q] <= st_wstrb_i;
        end
    end

`ifdef SB_FWD_EN
    logic               fwd_valid_q;
    logic [LDTAG_W-1:0] fwd_tag_q;
    logic [XLEN-1:0]    fwd_data_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            fwd_valid_q <= 1'b0;
            fwd_tag_q   <= '0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= fwd_take;
            if (fwd_take) begin
                fwd_tag_q  <= ld_tag_i;
                fwd_data_q <= ent_data_q[yng_idx];
            end
        end
    end

    assign fwd_valid_o = fwd_valid_q;
    assign fwd_tag_o   = fwd_tag_q;
    assign fwd_data_o  = fwd_data_q;
`else
    assign fwd_valid_o = 1'b0;
    assign fwd_tag_o   = '0;
    assign fwd_data_o  = '0;
`endif

    assign mreq_we_o    = mreq_we_q;
    assign mreq_addr_o  = mreq_addr_q;
    assign mreq_wdata_o = mreq_wdata_q;
    assign mreq_wstrb_o = mreq_wstrb_q;
    assign mreq_tag_o   = mreq_tag_q;
    assign sb_count_o   = count_q;
    assign sb_empty_o   = (count_q == '0) && !(mreq_valid_o && mreq_we_q);

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed bench for store_drain_buffer: ordering, full rule, RAW stalls, starvation, forwarding.
module tb_store_drain_buffer;

    localparam int XLEN = 32;
    localparam int TW   = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            st_valid, st_ready, ld_valid, ld_ready;
    logic [XLEN-1:0] st_addr, st_wdata, ld_addr;
    logic [3:0]      st_wstrb;
    logic [TW-1:0]   ld_tag;
    logic            mreq_valid, mreq_ready, mreq_we;
    logic [XLEN-1:0] mreq_addr, mreq_wdata;
    logic [3:0]      mreq_wstrb;
    logic [TW-1:0]   mreq_tag;
    logic            fwd_valid;
    logic [TW-1:0]   fwd_tag;
    logic [XLEN-1:0] fwd_data;
    logic            sb_empty;
    logic [2:0]      sb_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    store_drain_buffer #(.DEPTH(4), .XLEN(XLEN), .LDTAG_W(TW), .STARVE_LIM(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .st_valid_i(st_valid), .st_ready_o(st_ready), .st_addr_i(st_addr),
        .st_wdata_i(st_wdata), .st_wstrb_i(st_wstrb),
        .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_addr_i(ld_addr), .ld_tag_i(ld_tag),
        .mreq_valid_o(mreq_valid), .mreq_ready_i(mreq_ready), .mreq_we_o(mreq_we),
        .mreq_addr_o(mreq_addr), .mreq_wdata_o(mreq_wdata), .mreq_wstrb_o(mreq_wstrb),
        .mreq_tag_o(mreq_tag),
        .fwd_valid_o(fwd_valid), .fwd_tag_o(fwd_tag), .fwd_data_o(fwd_data),
        .sb_empty_o(sb_empty), .sb_count_o(sb_count)
    );

    task automatic clr();
        st_valid = 0; st_addr = '0; st_wdata = '0; st_wstrb = '0;
        ld_valid = 0; ld_addr = '0; ld_tag = '0; mreq_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        clr();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        st_valid = 1; st_addr = a; st_wdata = d; st_wstrb = s;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (mreq_valid !== 1'b0) begin failures++; $display("FAIL reset_mreq_valid got=%b exp=0", mreq_valid); end
        checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL reset_st_ready got=%b exp=1", st_ready); end
        checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL reset_sb_empty got=%b exp=1", sb_empty); end
        checks++; if (sb_count !== 3'd0) begin failures++; $display("FAIL reset_sb_count got=%0d exp=0", sb_count); end
        checks++; if (fwd_valid !== 1'b0) begin failures++; $display("FAIL reset_fwd_valid got=%b exp=0", fwd_valid); end
    endtask

    task automatic test_store_order();
        logic [31:0] got_a [4];
        logic [31:0] got_d [4];
        int n = 0;
        int peak = 0;
        do_reset();
        mreq_ready = 1;
        for (int c = 0; c < 20; c++) begin
            if (c < 4) store(32'h100 + 32'(4 * c), 32'hA0 + 32'(c), 4'hF);
            else st_valid = 0;
            #1;
            if (mreq_valid && mreq_ready) begin
                checks++; if (mreq_we !== 1'b1) begin failures++; $display("FAIL order_we idx=%0d got=%b exp=1", n, mreq_we); end
                if (n < 4) begin got_a[n] = mreq_addr; got_d[n] = mreq_wdata; end
                n++;
            end
            if (int'(sb_count) > peak) peak = int'(sb_count);
            @(negedge clk);
        end
        #1;
        checks++; if (n !== 4) begin failures++; $display("FAIL order_count got=%0d exp=4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            checks++;
            if (got_a[i] !== 32'h100 + 32'(4 * i) || got_d[i] !== 32'hA0 + 32'(i)) begin
                failures++;
                $display("FAIL order_req%0d got=%h/%h exp=%h/%h", i, got_a[i], got_d[i], 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            end
        end
        checks++; if (peak !== 2) begin failures++; $display("FAIL order_peak got=%0d exp=2", peak); end
        checks++; if (sb_empty !== 1'b1 || sb_count !== 3'd0) begin failures++; $display("FAIL order_drained empty=%b count=%0d exp=1/0", sb_empty, sb_count); end
    endtask

    task automatic test_full();
        int guard = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            store(32'h300 + 32'(4 * i), 32'hB0 + 32'(i), 4'hF);
            #1;
            checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL full_accept%0d got=%b exp=1", i, st_ready); end
            @(negedge clk);
        end
        store(32'h310, 32'hB4, 4'hF);
        #1;
        checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL full_st_ready got=%b exp=0", st_ready); end
        checks++; if (sb_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", sb_count); end
        @(negedge clk);
        st_valid = 0; ld_valid = 1; ld_addr = 32'h200; ld_tag = 4'd5;
        #1;
        checks++; if (ld_ready !== 1'b0 || mreq_addr !== 32'h300) begin failures++; $display("FAIL full_stalled ld_ready=%b addr=%h exp=0/300", ld_ready, mreq_addr); end
        @(negedge clk);
        mreq_ready = 1;
        #1;
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL full_rule ld_ready=%b exp=0", ld_ready); end
        @(negedge clk);
        #1;
        checks++; if (mreq_we !== 1'b1 || mreq_addr !== 32'h304) begin failures++; $display("FAIL full_second we=%b addr=%h exp=1/304", mreq_we, mreq_addr); end
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL full_load_wins ld_ready=%b exp=1", ld_ready); end
        @(negedge clk);
        ld_valid = 0;
        #1;
        checks++;
        if (mreq_we !== 1'b0 || mreq_addr !== 32'h200 || mreq_tag !== 4'd5 || mreq_wdata !== 32'h0 || mreq_wstrb !== 4'h0) begin
            failures++;
            $display("FAIL full_load_req we=%b addr=%h tag=%0d wd=%h ws=%h exp=0/200/5/0/0", mreq_we, mreq_addr, mreq_tag, mreq_wdata, mreq_wstrb);
        end
        while (!(sb_empty && !mreq_valid) && guard < 12) begin
            @(negedge clk); #1; guard++;
        end
        checks++; if (!(sb_empty && !mreq_valid)) begin failures++; $display("FAIL full_drain empty=%b mreq_valid=%b exp=1/0", sb_empty, mreq_valid); end
    endtask

    task automatic test_alias();
        do_reset();
        store(32'h40, 32'h11111111, 4'h3);
        @(negedge clk);
        st_valid = 0; ld_valid = 1; ld_addr = 32'h40; ld_tag = 4'd1;
        #1;
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL alias_stall0 ld_ready=%b exp=0", ld_ready); end
        @(negedge clk);
        #1;
        checks++; if (ld_ready !== 1'b0 || mreq_valid !== 1'b1 || mreq_we !== 1'b1) begin failures++; $display("FAIL alias_stall1 ld_ready=%b valid=%b we=%b exp=0/1/1", ld_ready, mreq_valid, mreq_we); end
        @(negedge clk);
        mreq_ready = 1;
        #1;
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL alias_release ld_ready=%b exp=1", ld_ready); end
        @(negedge clk);
        ld_valid = 0;
        #1;
        checks++; if (mreq_valid !== 1'b1 || mreq_we !== 1'b0 || mreq_addr !== 32'h40 || mreq_tag !== 4'd1) begin failures++; $display("FAIL alias_load_req valid=%b we=%b addr=%h tag=%0d exp=1/0/40/1", mreq_valid, mreq_we, mreq_addr, mreq_tag); end
        checks++; if (sb_empty !== 1'b1) begin failures++; $display("FAIL alias_empty got=%b exp=1", sb_empty); end

        do_reset();
        store(32'h40, 32'h22222222, 4'h3);
        @(negedge clk);
        st_valid = 0; ld_valid = 1; ld_addr = 32'h44; ld_tag = 4'd2;
        #1;
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL noalias_ready got=%b exp=1", ld_ready); end
        @(negedge clk);
        ld_valid = 0;
        #1;
        checks++; if (mreq_we !== 1'b0 || mreq_addr !== 32'h44 || mreq_tag !== 4'd2 || sb_count !== 3'd1) begin failures++; $display("FAIL noalias_req we=%b addr=%h tag=%0d cnt=%0d exp=0/44/2/1", mreq_we, mreq_addr, mreq_tag, sb_count); end

        do_reset();
        store(32'h50, 32'h33333333, 4'hF);
        ld_valid = 1; ld_addr = 32'h50; ld_tag = 4'd4;
        #1;
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL alias_incoming ld_ready=%b exp=0", ld_ready); end
        @(negedge clk);
        clr();
    endtask

    task automatic test_starve();
        int losses = 0;
        bit won = 0;
        int la = 0;
        do_reset();
        mreq_ready = 1;
        store(32'h60, 32'h44444444, 4'hF);
        @(negedge clk);
        st_valid = 0;
        for (int c = 0; c < 20 && !won; c++) begin
            ld_valid = 1; ld_addr = 32'h500 + 32'(4 * la); ld_tag = 4'(la);
            #1;
            if (ld_ready) begin losses++; la++; end
            else won = 1;
            @(negedge clk);
        end
        #1;
        checks++; if (won !== 1'b1 || losses !== 8) begin failures++; $display("FAIL starve_losses won=%b losses=%0d exp=1/8", won, losses); end
        checks++; if (mreq_we !== 1'b1 || mreq_addr !== 32'h60) begin failures++; $display("FAIL starve_store we=%b addr=%h exp=1/60", mreq_we, mreq_addr); end
        ld_valid = 0;
    endtask

    task automatic test_fwd();
        do_reset();
        store(32'h80, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        st_valid = 0; ld_valid = 1; ld_addr = 32'h80; ld_tag = 4'd3;
        #1;
`ifdef SB_FWD_EN
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL fwd_ready got=%b exp=1", ld_ready); end
        @(negedge clk);
        ld_valid = 0;
        #1;
        checks++; if (fwd_valid !== 1'b1 || fwd_tag !== 4'd3 || fwd_data !== 32'hDEADBEEF) begin failures++; $display("FAIL fwd_resp v=%b tag=%0d data=%h exp=1/3/deadbeef", fwd_valid, fwd_tag, fwd_data); end
        checks++; if (mreq_we !== 1'b1 || mreq_addr !== 32'h80) begin failures++; $display("FAIL fwd_no_load_req we=%b addr=%h exp=1/80", mreq_we, mreq_addr); end
        @(negedge clk);
        #1;
        checks++; if (fwd_valid !== 1'b0) begin failures++; $display("FAIL fwd_pulse got=%b exp=0", fwd_valid); end
`else
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL nofwd_stall got=%b exp=0", ld_ready); end
        @(negedge clk);
        #1;
        checks++; if (fwd_valid !== 1'b0 || ld_ready !== 1'b0) begin failures++; $display("FAIL nofwd_resp fwd=%b ld_ready=%b exp=0/0", fwd_valid, ld_ready); end
        ld_valid = 0;
`endif
        do_reset();
        store(32'h80, 32'hDEADBEEF, 4'h3);
        @(negedge clk);
        st_valid = 0; ld_valid = 1; ld_addr = 32'h80; ld_tag = 4'd3;
        #1;
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL partial_stall got=%b exp=0", ld_ready); end
        @(negedge clk);
        #1;
        checks++; if (fwd_valid !== 1'b0 || ld_ready !== 1'b0) begin failures++; $display("FAIL partial_nofwd fwd=%b ld_ready=%b exp=0/0", fwd_valid, ld_ready); end
        ld_valid = 0;
    endtask

    initial begin
        clr();
        test_reset();
        test_store_order();
        test_full();
        test_alias();
        test_starve();
        test_fwd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
